// File: rtl/ddr_unpack_fifo.sv
// ddr_unpack_fifo: width-converting FIFO, wide DDR words in, narrow units out.
// Ports: clk, reset, flush; wdata/we/full/words_free write side;
//   threshold/level/level_low/overflow status; out_data/out_valid/out_ready.
module ddr_unpack_fifo #(
  parameter int IN_BYTES       = 8,
  parameter int OUT_BYTES      = 1,
  parameter int DEPTH          = 8,
  parameter int FIRST_BYTE_LSB = 1,
  localparam int RATIO = IN_BYTES / OUT_BYTES,
  localparam int CAP   = DEPTH * RATIO,
  localparam int LW    = $clog2(CAP + 1),
  localparam int AW    = $clog2(DEPTH),
  localparam int IW    = IN_BYTES * 8,
  localparam int OW    = OUT_BYTES * 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [IW-1:0] wdata,
  input  logic          we,
  output logic          full,
  output logic [AW:0]   words_free,
  input  logic [LW-1:0] threshold,
  output logic [LW-1:0] level,
  output logic          level_low,
  output logic          overflow,
  output logic [OW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int LR = $clog2(RATIO);
  localparam int RW = $clog2(CAP) + 1;
  localparam int UW = (LR > 0) ? LR : 1;

  logic [IW-1:0] mem [DEPTH];

  logic [AW:0]   wptr;
  logic [RW-1:0] rptr;

  logic [RW-1:0] stored;
  logic [AW:0]   words_used;
  logic          clr;
  logic          wr_en;
  logic          load;

  logic [IW-1:0] rd_word;
  logic [UW-1:0] uidx;
  logic [UW-1:0] upos;
  logic [OW-1:0] unit;

  assign clr = reset | flush;

  // stored counts units; the read pointer's upper bits name its word.
  assign stored     = (RW'(wptr) << LR) - rptr;
  assign words_used = wptr - rptr[RW-1:LR];
  assign words_free = (AW+1)'(DEPTH) - words_used;
  assign full       = (words_used == (AW+1)'(DEPTH));

  assign level     = LW'(stored) + LW'(out_valid);
  assign level_low = (level < threshold);

  assign wr_en = we & ~full & ~clr;
  assign load  = (~out_valid | out_ready) & (stored != '0);

  generate
    if (LR > 0) begin : g_uidx
      assign uidx = rptr[UW-1:0];
    end else begin : g_uidx0
      assign uidx = '0;
    end
  endgenerate

  // Big-endian order picks units from the top of the word down.
  assign upos    = (FIRST_BYTE_LSB != 0) ? uidx : (UW'(RATIO - 1) - uidx);
  assign rd_word = mem[rptr[LR+AW-1:LR]];
  assign unit    = rd_word[upos*OW +: OW];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + 1'b1;
      end
      if (we && full) begin
        overflow <= 1'b1;
      end
      if (load) begin
        out_data  <= unit;
        out_valid <= 1'b1;
        rptr      <= rptr + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
